// File: rtl/pcecd_scsi_initiator.sv
// Host-side SCSI initiator for the PCE CD drive bus: selection, command
// streaming, DATA IN forwarding and STATUS/MESSAGE capture.
module pcecd_scsi_initiator #(
    parameter int CMD_MAX_LEN = 10,
    parameter int SEL_TIMEOUT = 1024,
    parameter int RST_CYCLES  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_wr,
    input  logic [7:0] i_cmd_data,
    input  logic       i_start,
    input  logic       i_bus_reset,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic       o_timeout,
    output logic [7:0] o_status,
    output logic [7:0] o_message,
    output logic       o_din_valid,
    output logic [7:0] o_din_data,
    input  logic       i_din_ready,
    output logic       o_sel,
    output logic       o_ack,
    output logic       o_rst,
    output logic [7:0] o_db,
    output logic       o_db_oe,
    input  logic [7:0] i_db,
    input  logic       i_bsy,
    input  logic       i_req,
    input  logic       i_msg,
    input  logic       i_cd,
    input  logic       i_io
);

    localparam int CMAX = (SEL_TIMEOUT > RST_CYCLES) ? SEL_TIMEOUT : RST_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_WAIT_REQ, S_ACK, S_DONE, S_RESET_BUS
    } state_t;

    typedef enum logic [2:0] {
        PH_CMD, PH_DIN, PH_STAT, PH_MSG, PH_BAD
    } phase_t;

    state_t        state;
    phase_t        phase;
    logic [7:0]    cbuf [CMD_MAX_LEN];
    logic [3:0]    wp;
    logic [3:0]    idx;
    logic [CW-1:0] cnt;
    logic          got_stat;
    logic          got_msg;
    logic          wr_en;

    always_comb begin
        phase = PH_BAD;
        case ({i_msg, i_cd, i_io})
            3'b010:  phase = PH_CMD;
            3'b001:  phase = PH_DIN;
            3'b011:  phase = PH_STAT;
            3'b111:  phase = PH_MSG;
            default: phase = PH_BAD;
        endcase
    end

    assign wr_en = i_cmd_wr && (state == S_IDLE) && !o_busy
                   && (wp != 4'(CMD_MAX_LEN));

    // Buffer contents need no reset; wp alone defines what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            cbuf[wp] <= i_cmd_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            wp          <= '0;
            idx         <= '0;
            cnt         <= '0;
            got_stat    <= 1'b0;
            got_msg     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_timeout   <= 1'b0;
            o_status    <= '0;
            o_message   <= '0;
            o_din_valid <= 1'b0;
            o_din_data  <= '0;
            o_sel       <= 1'b0;
            o_ack       <= 1'b0;
            o_rst       <= 1'b0;
            o_db        <= '0;
            o_db_oe     <= 1'b0;
        end else begin
            o_din_valid <= 1'b0;
            if (i_bus_reset) begin
                state     <= S_RESET_BUS;
                cnt       <= '0;
                o_rst     <= 1'b1;
                o_sel     <= 1'b0;
                o_ack     <= 1'b0;
                o_db_oe   <= 1'b0;
                o_db      <= '0;
                o_done    <= 1'b0;
                o_error   <= 1'b0;
                o_timeout <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (wr_en)
                            wp <= wp + 4'd1;
                        if (i_start && wp != 4'd0) begin
                            state    <= S_SELECT;
                            o_sel    <= 1'b1;
                            o_busy   <= 1'b1;
                            cnt      <= '0;
                            idx      <= '0;
                            got_stat <= 1'b0;
                            got_msg  <= 1'b0;
                        end else if (i_start) begin
                            state   <= S_DONE;
                            o_done  <= 1'b1;
                            o_error <= 1'b1;
                        end
                    end
                    S_SELECT: begin
                        if (i_bsy) begin
                            o_sel <= 1'b0;
                            state <= S_WAIT_REQ;
                        end else if (cnt == CW'(SEL_TIMEOUT - 1)) begin
                            o_sel     <= 1'b0;
                            o_done    <= 1'b1;
                            o_timeout <= 1'b1;
                            o_busy    <= 1'b0;
                            wp        <= '0;
                            state     <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_WAIT_REQ: begin
                        if (!i_bsy) begin
                            o_done  <= 1'b1;
                            o_error <= !(got_stat && got_msg);
                            o_busy  <= 1'b0;
                            wp      <= '0;
                            state   <= S_DONE;
                        end else if (i_req) begin
                            case (phase)
                                PH_CMD: begin
                                    if (idx < wp) begin
                                        o_db    <= cbuf[idx];
                                        o_db_oe <= 1'b1;
                                        idx     <= idx + 4'd1;
                                        o_ack   <= 1'b1;
                                        state   <= S_ACK;
                                    end else begin
                                        state <= S_RESET_BUS;
                                        cnt   <= '0;
                                        o_rst <= 1'b1;
                                    end
                                end
                                PH_DIN: begin
                                    if (i_din_ready) begin
                                        o_din_data  <= i_db;
                                        o_din_valid <= 1'b1;
                                        o_ack       <= 1'b1;
                                        state       <= S_ACK;
                                    end
                                end
                                PH_STAT: begin
                                    o_status <= i_db;
                                    got_stat <= 1'b1;
                                    o_ack    <= 1'b1;
                                    state    <= S_ACK;
                                end
                                PH_MSG: begin
                                    o_message <= i_db;
                                    got_msg   <= 1'b1;
                                    o_ack     <= 1'b1;
                                    state     <= S_ACK;
                                end
                                default: begin
                                    state <= S_RESET_BUS;
                                    cnt   <= '0;
                                    o_rst <= 1'b1;
                                end
                            endcase
                        end
                    end
                    S_ACK: begin
                        if (!i_req) begin
                            o_ack   <= 1'b0;
                            o_db_oe <= 1'b0;
                            state   <= S_WAIT_REQ;
                        end
                    end
                    S_DONE: begin
                        o_done    <= 1'b0;
                        o_error   <= 1'b0;
                        o_timeout <= 1'b0;
                        state     <= S_IDLE;
                    end
                    S_RESET_BUS: begin
                        if (cnt == CW'(RST_CYCLES - 1)) begin
                            o_rst <= 1'b0;
                            if (o_busy) begin
                                o_done  <= 1'b1;
                                o_error <= 1'b1;
                                o_busy  <= 1'b0;
                                wp      <= '0;
                                state   <= S_DONE;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcecd_scsi_initiator.sv
// Directed bench for pcecd_scsi_initiator: the initial block plays the
// CD drive target and checks the initiator with immediate assertions.
module tb_pcecd_scsi_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_cmd_wr = 1'b0;
    logic [7:0] i_cmd_data = '0;
    logic       i_start = 1'b0;
    logic       i_bus_reset = 1'b0;
    logic       i_din_ready = 1'b1;
    logic [7:0] i_db = '0;
    logic       i_bsy = 1'b0;
    logic       i_req = 1'b0;
    logic       i_msg = 1'b0;
    logic       i_cd = 1'b0;
    logic       i_io = 1'b0;

    logic       o_busy, o_done, o_error, o_timeout;
    logic [7:0] o_status, o_message, o_din_data, o_db;
    logic       o_din_valid, o_sel, o_ack, o_rst, o_db_oe;

    int tests = 0;
    int fails = 0;

    int         ack_rises = 0;
    logic       ack_q = 1'b0;
    logic [7:0] din_q [$];

    localparam logic [2:0] PH_CMD  = 3'b010;
    localparam logic [2:0] PH_DIN  = 3'b001;
    localparam logic [2:0] PH_STAT = 3'b011;
    localparam logic [2:0] PH_MSG  = 3'b111;
    localparam logic [2:0] PH_DOUT = 3'b000;

    pcecd_scsi_initiator dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_wr    (i_cmd_wr),
        .i_cmd_data  (i_cmd_data),
        .i_start     (i_start),
        .i_bus_reset (i_bus_reset),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_timeout   (o_timeout),
        .o_status    (o_status),
        .o_message   (o_message),
        .o_din_valid (o_din_valid),
        .o_din_data  (o_din_data),
        .i_din_ready (i_din_ready),
        .o_sel       (o_sel),
        .o_ack       (o_ack),
        .o_rst       (o_rst),
        .o_db        (o_db),
        .o_db_oe     (o_db_oe),
        .i_db        (i_db),
        .i_bsy       (i_bsy),
        .i_req       (i_req),
        .i_msg       (i_msg),
        .i_cd        (i_cd),
        .i_io        (i_io)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_ack && !ack_q)
            ack_rises++;
        ack_q = o_ack;
        if (o_din_valid)
            din_q.push_back(o_din_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        i_cmd_wr   = 1'b1;
        i_cmd_data = d;
        @(negedge clk);
        i_cmd_wr   = 1'b0;
    endtask

    task automatic begin_txn(input string tag);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk({tag, "_sel_up"}, o_sel, 1);
        chk({tag, "_busy_up"}, o_busy, 1);
        i_bsy = 1'b1;
        @(negedge clk);
        chk({tag, "_sel_drop"}, o_sel, 0);
    endtask

    task automatic xfer(input string tag, input logic [2:0] ph,
                        input logic [7:0] d, output logic [7:0] got,
                        output logic dv, output logic oe);
        bit ok;
        ok = 1'b0;
        {i_msg, i_cd, i_io} = ph;
        i_db  = d;
        i_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_ack) begin
                ok = 1'b1;
                break;
            end
        end
        got = o_db;
        dv  = o_din_valid;
        oe  = o_db_oe;
        chk({tag, "_ack"}, ok, 1);
        i_req = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!o_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_ack_drop"}, ok, 1);
    endtask

    task automatic bus_free(input string tag, input logic exp_err);
        bit seen;
        seen  = 1'b0;
        i_bsy = 1'b0;
        i_req = 1'b0;
        {i_msg, i_cd, i_io} = 3'b000;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, seen, 1);
        chk({tag, "_error"}, o_error, exp_err);
        chk({tag, "_busy"}, o_busy, 0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] cdb1 [6];
        logic [7:0] cdb4 [6];
        logic [7:0] got;
        logic       dv, oe;
        int         a0, n;
        bit         bad;

        cdb1 = '{8'h08, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00};
        cdb4 = '{8'h28, 8'h01, 8'h5A, 8'h22, 8'h33, 8'h44};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {o_busy, o_done, o_error, o_timeout, o_sel,
                         o_ack, o_rst, o_db_oe, o_din_valid}, 0);
        chk("rst_db", o_db, 8'h00);
        chk("rst_stat_msg", {o_status, o_message, o_din_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Six-byte CDB, STATUS 0x00, MESSAGE 0x00, bus free
        foreach (cdb1[i]) write_byte(cdb1[i]);
        a0 = ack_rises;
        begin_txn("t1");
        for (int i = 0; i < 6; i++) begin
            xfer("t1_cmd", PH_CMD, 8'hFF, got, dv, oe);
            chk($sformatf("t1_db%0d", i), got, cdb1[i]);
            chk($sformatf("t1_oe%0d", i), oe, 1);
        end
        xfer("t1_stat", PH_STAT, 8'h00, got, dv, oe);
        xfer("t1_msg", PH_MSG, 8'h00, got, dv, oe);
        chk("t1_status", o_status, 8'h00);
        chk("t1_message", o_message, 8'h00);
        bus_free("t1", 1'b0);
        chk("t1_ack_count", ack_rises - a0, 8);

        // Selection timeout
        write_byte(8'h00);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        for (int k = 0; k < 1100; k++) begin
            if (!o_sel) break;
            n++;
            @(negedge clk);
        end
        chk("t2_sel_cycles", n, 1024);
        chk("t2_done", o_done, 1);
        chk("t2_timeout", o_timeout, 1);
        chk("t2_busy", o_busy, 0);
        @(negedge clk);
        chk("t2_done_fall", o_done, 0);

        // DATA IN with a stall on byte 2
        write_byte(8'h28);
        begin_txn("t3");
        xfer("t3_cmd", PH_CMD, 8'hFF, got, dv, oe);
        din_q.delete();
        xfer("t3_d1", PH_DIN, 8'hA1, got, dv, oe);
        chk("t3_dv1", dv, 1);
        {i_msg, i_cd, i_io} = PH_DIN;
        i_db        = 8'hA2;
        i_req       = 1'b1;
        i_din_ready = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (o_ack || o_din_valid) bad = 1'b1;
        end
        chk("t3_stall_no_ack", bad, 0);
        i_din_ready = 1'b1;
        xfer("t3_d2", PH_DIN, 8'hA2, got, dv, oe);
        chk("t3_dv2", dv, 1);
        xfer("t3_d3", PH_DIN, 8'hA3, got, dv, oe);
        xfer("t3_d4", PH_DIN, 8'hA4, got, dv, oe);
        chk("t3_din_count", din_q.size(), 4);
        if (din_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("t3_din%0d", i), din_q[i], 8'hA1 + 8'(i));
        end
        xfer("t3_stat", PH_STAT, 8'h02, got, dv, oe);
        xfer("t3_msg", PH_MSG, 8'h80, got, dv, oe);
        chk("t3_status", o_status, 8'h02);
        chk("t3_message", o_message, 8'h80);
        bus_free("t3", 1'b0);

        // Bus reset during the third COMMAND byte
        foreach (cdb4[i]) write_byte(cdb4[i]);
        begin_txn("t4");
        xfer("t4_c0", PH_CMD, 8'hFF, got, dv, oe);
        xfer("t4_c1", PH_CMD, 8'hFF, got, dv, oe);
        {i_msg, i_cd, i_io} = PH_CMD;
        i_req = 1'b1;
        bad = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_ack) begin
                bad = 1'b0;
                break;
            end
        end
        chk("t4_c2_ack", bad, 0);
        chk("t4_c2_db", o_db, 8'h5A);
        i_bus_reset = 1'b1;
        @(negedge clk);
        i_bus_reset = 1'b0;
        i_req = 1'b0;
        i_bsy = 1'b0;
        chk("t4_ack_low", o_ack, 0);
        chk("t4_sel_low", o_sel, 0);
        chk("t4_rst_high", o_rst, 1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!o_rst) break;
            n++;
            @(negedge clk);
        end
        chk("t4_rst_cycles", n, 16);
        chk("t4_done", o_done, 1);
        chk("t4_error", o_error, 1);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("t4_wp_zero_done", o_done, 1);
        chk("t4_wp_zero_err", o_error, 1);
        chk("t4_wp_zero_busy", o_busy, 0);
        @(negedge clk);

        // Target enters DATA OUT
        write_byte(8'h0A);
        begin_txn("t5");
        xfer("t5_cmd", PH_CMD, 8'hFF, got, dv, oe);
        a0 = ack_rises;
        {i_msg, i_cd, i_io} = PH_DOUT;
        i_req = 1'b1;
        @(negedge clk);
        chk("t5_rst", o_rst, 1);
        chk("t5_no_ack", o_ack, 0);
        i_req = 1'b0;
        bus_free("t5", 1'b1);
        chk("t5_ack_count", ack_rises - a0, 0);

        // BSY drops after COMMAND without STATUS
        write_byte(8'h00);
        begin_txn("t6");
        xfer("t6_cmd", PH_CMD, 8'hFF, got, dv, oe);
        bus_free("t6", 1'b1);
        chk("t6_status_kept", o_status, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
